// File: rtl/serial_adder_8bit_if.sv
// Request/result bundle for the bit-serial adder: operands and start go in,
// the WIDTH+1-bit result and busy/done status come back.
interface serial_adder_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   s;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  s, busy, done
    );

    modport slave (
        input  start, a, b,
        output s, busy, done
    );
endinterface

// File: rtl/serial_adder_8bit.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flop reused over
// WIDTH cycles. The result is {carry_out, sum} in WIDTH+1 bits.
module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_8bit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   s_q, s_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sum_bit;
    logic             carry_out;
    logic             last_bit;
    logic [WIDTH-1:0] bit_sel;

    assign sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_out = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign last_bit  = (cnt_q == CW'(WIDTH - 1));

    // One-hot decode of the bit position being written this cycle.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (cnt_q == CW'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                // DONE accepts a new start directly so operations can run back-to-back.
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    s_d     = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (bit_sel[i]) begin
                        s_d[i] = sum_bit;
                    end
                end
                carry_d = carry_out;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    s_d[WIDTH] = carry_out;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_serial_adder_8bit.sv
// Directed bench for serial_adder_8bit: a vector table of additions plus
// hand-written sequences for hold, start-while-busy, back-to-back and reset.
module tb_serial_adder_8bit;
    logic clk;
    logic rst;

    serial_adder_8bit_if #(.WIDTH(8)) ifc ();

    serial_adder_8bit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp_s;
    } vec_t;

    int applied;
    int miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one start at the next negedge, then follow the operation to done.
    // Returns after sampling the done cycle (#1 after the completing edge).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_s,
                          input string name);
        int busy_cnt;
        int lat;
        bit got;
        @(negedge clk);
        ifc.a     = a;
        ifc.b     = b;
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        busy_cnt  = 0;
        lat       = 0;
        got       = 1'b0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (ifc.busy) busy_cnt++;
            if (ifc.busy && ifc.done) begin
                miscompares++;
                $display("FAIL %s_overlap: busy and done both high", name);
            end
            @(posedge clk);
            #1;
            if (ifc.done) begin
                got = 1'b1;
                lat = c;
            end
        end
        if (!got) begin
            applied++;
            miscompares++;
            $display("FAIL %s_timeout: got no done, expected done within 20 cycles", name);
        end else begin
            chk({name, "_latency"}, lat, 8);
            chk({name, "_busy"}, busy_cnt, 8);
            chk({name, "_s"}, {23'd0, ifc.s}, {23'd0, exp_s});
            chk({name, "_busy_in_done"}, {31'd0, ifc.busy}, 32'd0);
        end
        $display("op %s: a=%02h b=%02h s=%03h exp=%03h latency=%0d", name, a, b, ifc.s, exp_s, lat);
    endtask

    vec_t vecs[8];
    int   extra_done;

    initial begin
        applied     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ifc.start   = 1'b0;
        ifc.a       = '0;
        ifc.b       = '0;

        vecs[0] = '{8'h5A, 8'h3C, 9'h096};
        vecs[1] = '{8'hFF, 8'h01, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 9'h1FE};
        vecs[3] = '{8'h12, 8'h34, 9'h046};
        vecs[4] = '{8'hAA, 8'h55, 9'h0FF};
        vecs[5] = '{8'h01, 8'hFF, 9'h100};
        vecs[6] = '{8'h7F, 8'h01, 9'h080};
        vecs[7] = '{8'h00, 8'h00, 9'h000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_s", {23'd0, ifc.s}, 32'd0);
        chk("reset_busy", {31'd0, ifc.busy}, 32'd0);
        chk("reset_done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table of independent additions, each separated by an idle cycle.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_s, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, ifc.done}, 32'd0);
        end

        // Zero result then hold: operands wiggle with start low.
        run_op(8'h00, 8'h00, 9'h000, "zero");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ifc.a = 8'hC3 ^ 8'(c);
            ifc.b = 8'h5A + 8'(c);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_s", c), {23'd0, ifc.s}, 32'd0);
            chk($sformatf("hold%0d_done", c), {31'd0, ifc.done}, 32'd0);
        end

        // Start pulse during ADD must be ignored.
        begin
            int lat;
            bit got;
            @(negedge clk);
            ifc.a = 8'h10; ifc.b = 8'h20; ifc.start = 1'b1;
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            lat = 0; got = 1'b0;
            for (int c = 1; c <= 20 && !got; c++) begin
                if (c == 3) begin
                    ifc.a = 8'hFF; ifc.b = 8'hFF; ifc.start = 1'b1;
                end else begin
                    ifc.start = 1'b0;
                end
                @(posedge clk);
                #1;
                if (ifc.done) begin
                    got = 1'b1;
                    lat = c;
                end
            end
            ifc.start = 1'b0;
            chk("busy_start_got_done", {31'd0, got}, 32'd1);
            chk("busy_start_latency", lat, 8);
            chk("busy_start_s", {23'd0, ifc.s}, 32'h030);
            $display("op busy_start: a=10 b=20 s=%03h exp=030 latency=%0d", ifc.s, lat);
            extra_done = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                if (ifc.done) extra_done++;
            end
            chk("busy_start_single_done", extra_done, 0);
        end

        // Back-to-back: second start lands in the DONE cycle.
        run_op(8'h5A, 8'h3C, 9'h096, "b2b_first");
        run_op(8'h80, 8'h80, 9'h100, "b2b_second");

        // Reset during ADD aborts with no done pulse.
        @(posedge clk);
        @(negedge clk);
        ifc.a = 8'hAA; ifc.b = 8'h55; ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_s", {23'd0, ifc.s}, 32'd0);
        chk("rst_mid_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, ifc.done}, 32'd0);
        $display("op rst_mid: a=AA b=55 aborted, s=%03h busy=%0b", ifc.s, ifc.busy);
        @(negedge clk);
        rst = 1'b0;
        extra_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (ifc.done || ifc.busy) extra_done++;
        end
        chk("rst_mid_no_done", extra_done, 0);
        run_op(8'h01, 8'h02, 9'h003, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
